send_arbiter: RTL and testbench



---
 rtl/send_arbiter.sv | 140 ++++++++++++++
 tb/tb_send_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/send_arbiter.sv
// Round-robin, packet-granular arbiter feeding the framing send ring and
// its packet-length FIFO from NREQ independent byte producers.
module send_arbiter #(
  parameter int NREQ     = 4,
  parameter int LEN_BITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [8*NREQ-1:0]     req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [7:0]            send_ring_data,
  output logic                  send_ring_wr_en,
  input  logic                  send_ring_full,
  output logic [LEN_BITS-1:0]   send_fifo_data,
  output logic                  send_fifo_wr_en,
  input  logic                  send_fifo_full,
  output logic [NREQ-1:0]       grant,
  output logic                  overflow
);

  localparam int IW = $clog2(NREQ);
  localparam logic [LEN_BITS-1:0] MAX_LEN = {LEN_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DISCARD,
    COMMIT
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [NREQ-1:0]     grant_d;
  logic [LEN_BITS-1:0] count;
  logic [LEN_BITS-1:0] count_d;
  logic [IW-1:0]       last;
  logic [IW-1:0]       last_d;
  logic                overflow_d;

  logic [NREQ-1:0]     pick;
  logic [IW-1:0]       owner;
  logic [7:0]          owner_data;
  logic                owner_valid;
  logic                owner_last;

  // Walk from the farthest slot back to last+1 so the nearest one wins.
  always_comb begin
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[IW'((int'(last) + k) % NREQ)]) begin
        pick = '0;
        pick[IW'((int'(last) + k) % NREQ)] = 1'b1;
      end
    end
  end

  always_comb begin
    owner      = '0;
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        owner      = IW'(i);
        owner_data = req_data[8*i +: 8];
      end
    end
  end

  assign owner_valid    = |(req_valid & grant);
  assign owner_last     = |(req_last & grant);
  assign send_ring_data = owner_data;
  assign send_fifo_data = count;

  always_comb begin
    state_d         = state;
    grant_d         = grant;
    count_d         = count;
    last_d          = last;
    overflow_d      = 1'b0;
    req_ready       = '0;
    send_ring_wr_en = 1'b0;
    send_fifo_wr_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          state_d = STREAM;
        end
      end
      STREAM: begin
        req_ready = grant & {NREQ{!send_ring_full}};
        if (owner_valid && !send_ring_full) begin
          send_ring_wr_en = 1'b1;
          count_d         = count + 1'b1;
          if (owner_last) begin
            state_d = COMMIT;
          end else if (count == MAX_LEN - 1'b1) begin
            overflow_d = 1'b1;
            state_d    = DISCARD;
          end
        end
      end
      DISCARD: begin
        // Truncated tail: drain the owner without touching the ring.
        req_ready = grant;
        if (owner_valid && owner_last) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (!send_fifo_full) begin
          send_fifo_wr_en = 1'b1;
          last_d          = owner;
          grant_d         = '0;
          count_d         = '0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      count    <= '0;
      last     <= IW'(NREQ - 1);
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      count    <= count_d;
      last     <= last_d;
      overflow <= overflow_d;
    end
  end

endmodule

// File: tb/tb_send_arbiter.sv
// Bench for send_arbiter: cycle table, directed packet scenarios and
// randomized traffic against a packet-level scoreboard.
module tb_send_arbiter;

  localparam int NREQ = 4;
  localparam int LB   = 7;
  localparam int MAX  = 127;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  send_ring_data;
  logic        send_ring_wr_en;
  logic        send_ring_full;
  logic [6:0]  send_fifo_data;
  logic        send_fifo_wr_en;
  logic        send_fifo_full;
  logic [3:0]  grant;
  logic        overflow;

  always #5 clk = ~clk;

  send_arbiter #(.NREQ(NREQ), .LEN_BITS(LB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .send_ring_data(send_ring_data),
    .send_ring_wr_en(send_ring_wr_en),
    .send_ring_full(send_ring_full),
    .send_fifo_data(send_fifo_data),
    .send_fifo_wr_en(send_fifo_wr_en),
    .send_fifo_full(send_fifo_full),
    .grant(grant), .overflow(overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        r;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        rf;
    logic        ff;
    logic [3:0]  e_rdy;
    logic        e_wr;
    logic [7:0]  e_data;
    logic        e_fwr;
    logic [6:0]  e_flen;
    logic [3:0]  e_gnt;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[18];

  task automatic raw(input logic r, input logic [3:0] v,
                     input logic [31:0] d, input logic [3:0] l,
                     input logic rf, input logic ff);
    @(negedge clk);
    rst            = r;
    req_valid      = v;
    req_data       = d;
    req_last       = l;
    send_ring_full = rf;
    send_fifo_full = ff;
    #1;
  endtask

  // Producer queues and the packet-level expectations derived from them.
  logic [7:0] qb[4][$];
  bit         ql[4][$];
  logic [7:0] exp_ring[4][$];
  int         exp_len[4][$];
  int         glog[$];

  int         owner, m_last, wcount;
  bit         done, rel_pend, idle_seen, ovf_due;
  logic [3:0] prev_valid;
  bit         rnd, rf_set, ff_set;
  int         n_ring = 0;
  int         n_ovf  = 0;
  int         n_fifo = 0;

  function automatic int rr_pick(input logic [3:0] v, input int lst);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (lst + k) % NREQ;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic init_mon();
    owner      = -1;
    m_last     = NREQ - 1;
    wcount     = 0;
    done       = 0;
    rel_pend   = 0;
    idle_seen  = 0;
    ovf_due    = 0;
    prev_valid = '0;
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) begin
      logic [7:0] x;
      x = 8'($urandom);
      qb[r].push_back(x);
      ql[r].push_back(b == len - 1);
      if (b < MAX) exp_ring[r].push_back(x);
    end
    exp_len[r].push_back(len < MAX ? len : MAX);
  endtask

  task automatic tick();
    logic [3:0] eg, er;
    logic [7:0] eb;
    bit         hs, ewr, efw, lst;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (qb[i].size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = qb[i][0];
        req_last[i]        = ql[i][0];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    send_ring_full = rnd ? ($urandom_range(0, 4) == 0) : rf_set;
    send_fifo_full = rnd ? ($urandom_range(0, 3) == 0) : ff_set;
    #1;
    if (rel_pend) begin
      m_last   = owner;
      owner    = -1;
      wcount   = 0;
      done     = 0;
      rel_pend = 0;
    end
    if (owner < 0 && idle_seen) begin
      owner = rr_pick(prev_valid, m_last);
      glog.push_back(owner);
    end
    eg = (owner < 0) ? 4'b0 : (4'b1 << owner);
    chk("grant", grant, eg);
    er = '0;
    if (owner >= 0 && !done) begin
      if (wcount == MAX || !send_ring_full) er = eg;
    end
    chk("req_ready", req_ready, er);
    hs  = (owner >= 0) && req_valid[owner[1:0]] && er[owner[1:0]];
    lst = (owner >= 0) && req_last[owner[1:0]];
    ewr = hs && wcount < MAX;
    chk("ring_wr_en", send_ring_wr_en, ewr);
    if (ewr && send_ring_wr_en) begin
      eb = exp_ring[owner].size() > 0 ? exp_ring[owner].pop_front() : 8'hxx;
      chk("ring_data", send_ring_data, eb);
    end
    efw = (owner >= 0) && done && !send_fifo_full;
    chk("fifo_wr_en", send_fifo_wr_en, efw);
    if (efw) begin
      if (send_fifo_wr_en) begin
        chk("fifo_len", send_fifo_data,
            exp_len[owner].size() > 0 ? exp_len[owner].pop_front() : -1);
      end
      rel_pend = 1;
    end
    chk("overflow", overflow, ovf_due);
    n_ring += send_ring_wr_en;
    n_ovf  += overflow;
    n_fifo += send_fifo_wr_en;
    ovf_due = hs && wcount == MAX - 1 && !lst;
    if (hs) begin
      void'(qb[owner].pop_front());
      void'(ql[owner].pop_front());
      if (wcount < MAX) wcount++;
      if (lst) done = 1;
    end
    idle_seen  = (owner < 0) && (|req_valid);
    prev_valid = req_valid;
  endtask

  function automatic bit busy();
    for (int i = 0; i < 4; i++) if (qb[i].size() > 0) return 1;
    return owner >= 0;
  endfunction

  task automatic drain(input int budget);
    for (int c = 0; c < budget && busy(); c++) tick();
    if (busy()) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    raw(1'b1, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    raw(1'b1, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    init_mon();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, o0, f0;
    rnd = 0; rf_set = 0; ff_set = 0;
    tbl[0]  = '{1'b1, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b0, 7'd0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 32'hA1, 4'h0, 1'b0, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b0, 7'd0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'h1, 32'hA1, 4'h0, 1'b0, 1'b0,
                4'h1, 1'b1, 8'hA1, 1'b0, 7'd0, 4'h1, 1'b0};
    tbl[3]  = '{1'b0, 4'h1, 32'hA2, 4'h0, 1'b0, 1'b0,
                4'h1, 1'b1, 8'hA2, 1'b0, 7'd0, 4'h1, 1'b0};
    tbl[4]  = '{1'b0, 4'h1, 32'hA3, 4'h1, 1'b0, 1'b0,
                4'h1, 1'b1, 8'hA3, 1'b0, 7'd0, 4'h1, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b1, 7'd3, 4'h1, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b0, 7'd0, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 4'h4, 32'h005C0000, 4'h4, 1'b0, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b0, 7'd0, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 4'h4, 32'h005C0000, 4'h4, 1'b0, 1'b0,
                4'h4, 1'b1, 8'h5C, 1'b0, 7'd0, 4'h4, 1'b0};
    tbl[9]  = '{1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b1, 7'd1, 4'h4, 1'b0};
    tbl[10] = '{1'b0, 4'h5, 32'h00110022, 4'h5, 1'b0, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b0, 7'd0, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 4'h5, 32'h00110022, 4'h5, 1'b1, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b0, 7'd0, 4'h1, 1'b0};
    tbl[12] = '{1'b0, 4'h5, 32'h00110022, 4'h5, 1'b0, 1'b0,
                4'h1, 1'b1, 8'h22, 1'b0, 7'd0, 4'h1, 1'b0};
    tbl[13] = '{1'b0, 4'h4, 32'h00110022, 4'h4, 1'b0, 1'b1,
                4'h0, 1'b0, 8'h00, 1'b0, 7'd0, 4'h1, 1'b0};
    tbl[14] = '{1'b0, 4'h4, 32'h00110022, 4'h4, 1'b0, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b1, 7'd1, 4'h1, 1'b0};
    tbl[15] = '{1'b0, 4'h4, 32'h00110022, 4'h4, 1'b0, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b0, 7'd0, 4'h0, 1'b0};
    tbl[16] = '{1'b0, 4'h4, 32'h00110022, 4'h4, 1'b0, 1'b0,
                4'h4, 1'b1, 8'h11, 1'b0, 7'd0, 4'h4, 1'b0};
    tbl[17] = '{1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0,
                4'h0, 1'b0, 8'h00, 1'b1, 7'd1, 4'h4, 1'b0};

    raw(1'b1, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      raw(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rf, tbl[i].ff);
      chk($sformatf("t%0d_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("t%0d_ring_wr", i), send_ring_wr_en, tbl[i].e_wr);
      if (tbl[i].e_wr)
        chk($sformatf("t%0d_ring_data", i), send_ring_data, tbl[i].e_data);
      chk($sformatf("t%0d_fifo_wr", i), send_fifo_wr_en, tbl[i].e_fwr);
      if (tbl[i].e_fwr)
        chk($sformatf("t%0d_fifo_len", i), send_fifo_data, tbl[i].e_flen);
      chk($sformatf("t%0d_grant", i), grant, tbl[i].e_gnt);
      chk($sformatf("t%0d_overflow", i), overflow, tbl[i].e_ovf);
    end

    // Two contending requesters alternate per packet.
    do_reset();
    glog.delete();
    for (int p = 0; p < 4; p++) begin
      add_pkt(1, 2);
      add_pkt(2, 2);
    end
    drain(200);
    chk("rr_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      chk($sformatf("rr_order%0d", i), glog[i], (i % 2 == 0) ? 1 : 2);

    // Ring back-pressure mid-packet.
    add_pkt(3, 6);
    repeat (3) tick();
    rf_set = 1;
    r0 = n_ring;
    repeat (5) tick();
    chk("full_no_ring_writes", n_ring - r0, 0);
    rf_set = 0;
    drain(100);

    // Truncation at MAX_LEN and the exact-MAX boundary.
    r0 = n_ring;
    o0 = n_ovf;
    add_pkt(0, 130);
    add_pkt(2, 127);
    add_pkt(3, 128);
    drain(1000);
    chk("trunc_ring_writes", n_ring - r0, 3 * MAX);
    chk("trunc_overflows", n_ovf - o0, 2);

    // Length FIFO back-pressure holds the owner.
    ff_set = 1;
    f0 = n_fifo;
    add_pkt(1, 4);
    add_pkt(2, 3);
    repeat (16) tick();
    chk("ff_hold_grant", grant, 4'b0010);
    chk("ff_no_fifo_write", n_fifo - f0, 0);
    ff_set = 0;
    drain(100);

    // Random traffic with random gaps and back-pressure.
    rnd = 1;
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 9) == 0)
          add_pkt($urandom_range(0, 3), $urandom_range(120, 132));
        else
          add_pkt($urandom_range(0, 3), $urandom_range(1, 6));
      end
      tick();
    end
    drain(20000);
    rnd = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("left_len%0d", i), exp_len[i].size(), 0);
      chk($sformatf("left_ring%0d", i), exp_ring[i].size(), 0);
    end

    // Reset in the middle of a packet.
    raw(1'b1, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    raw(1'b0, 4'h4, 32'h00B10000, 4'h0, 1'b0, 1'b0);
    raw(1'b0, 4'h4, 32'h00B10000, 4'h0, 1'b0, 1'b0);
    chk("rm_byte1_wr", send_ring_wr_en, 1'b1);
    raw(1'b1, 4'h4, 32'h00B20000, 4'h0, 1'b0, 1'b0);
    chk("rm_grant_before", grant, 4'h4);
    raw(1'b0, 4'hF, 32'h44332211, 4'h0, 1'b0, 1'b0);
    chk("rm_grant", grant, 4'h0);
    chk("rm_ready", req_ready, 4'h0);
    chk("rm_ring_wr", send_ring_wr_en, 1'b0);
    chk("rm_fifo_wr", send_fifo_wr_en, 1'b0);
    chk("rm_overflow", overflow, 1'b0);
    raw(1'b0, 4'hF, 32'h44332211, 4'h0, 1'b0, 1'b0);
    chk("rm_first_grant", grant, 4'h1);
    chk("rm_first_data", send_ring_data, 8'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
